// File: rtl/flap_debouncer_if.sv
// Button-side bundle for flap_debouncer.
// master drives the raw button; slave returns the debounced results.
interface flap_debouncer_if;
    logic       btn_raw;
    logic       btn_level;
    logic       flap_pulse;
    logic [7:0] press_count;

    modport master (
        output btn_raw,
        input  btn_level,
        input  flap_pulse,
        input  press_count
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output flap_pulse,
        output press_count
    );
endinterface

// File: rtl/flap_debouncer.sv
// Push-button debouncer producing a one-cycle flap strobe and press count.
// Define FLAP_AUTO_REPEAT_EN to add periodic re-flaps while the button is held.
module flap_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 15000000
) (
    input  logic            clk,
    input  logic            reset,
    flap_debouncer_if.slave bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TV = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam logic [CW-1:0] TERM = CW'(TV);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            meta_q;
    logic            sync_q;
    logic            level_q;
    logic            pulse_q;
    logic [7:0]      count_q;

`ifdef FLAP_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam int RV = (REPEAT_CYCLES >= 1) ? REPEAT_CYCLES - 1 : 0;
    localparam logic [RW-1:0] RTERM = RW'(RV);
    logic [RW-1:0]   rep_q;
`endif

    // Two-flop synchronizer; the only consumer of the raw button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= bus.btn_raw;
            sync_q <= meta_q;
        end
    end

    // Debounce FSM; the count check sees the value about to be reached,
    // so a level held DEBOUNCE_CYCLES samples is accepted on that sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= 8'd0;
`ifdef FLAP_AUTO_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sync_q) begin
                        state_q <= PRESS_CHK;
                        cnt_q   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!sync_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == TERM) begin
                        state_q <= HELD;
                        level_q <= 1'b1;
                        pulse_q <= 1'b1;
                        count_q <= count_q + 8'd1;
`ifdef FLAP_AUTO_REPEAT_EN
                        rep_q   <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync_q) begin
                        state_q <= RELEASE_CHK;
                        cnt_q   <= '0;
                    end
`ifdef FLAP_AUTO_REPEAT_EN
                    else if (rep_q == RTERM) begin
                        rep_q   <= '0;
                        pulse_q <= 1'b1;
                        count_q <= count_q + 8'd1;
                    end else begin
                        rep_q <= rep_q + 1'b1;
                    end
`endif
                end
                RELEASE_CHK: begin
                    if (sync_q) begin
                        state_q <= HELD;
                    end else if (cnt_q == TERM) begin
                        state_q <= IDLE;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.flap_pulse  = pulse_q;
    assign bus.press_count = count_q;

endmodule

// File: tb/tb_flap_debouncer.sv
// Randomized scoreboard bench for flap_debouncer (DEBOUNCE=4, REPEAT=10).
// Reference model works on run lengths of synchronized samples.
module tb_flap_debouncer;

    localparam int D = 4;
    localparam int R = 10;

    typedef struct packed {
        logic       lvl;
        logic       pulse;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    flap_debouncer_if bus();

    flap_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    bit         m_d1, m_d2, m_lvl;
    int         m_run, m_rep;
    logic [7:0] m_cnt;

    task automatic step(input bit v, input bit r);
        exp_t e;
        bit   samp;
        bit   p;
        @(negedge clk);
        reset = r;
        bus.btn_raw = v;
        p = 1'b0;
        if (r) begin
            m_d1 = 0; m_d2 = 0; m_lvl = 0;
            m_run = 0; m_rep = 0; m_cnt = 8'd0;
        end else begin
            samp = m_d2;
            m_d2 = m_d1;
            m_d1 = v;
            if (samp != m_lvl) begin
                m_run++;
                if (m_run == D) begin
                    m_lvl = samp;
                    m_run = 0;
                    if (m_lvl) begin
                        p = 1'b1;
                        m_cnt = m_cnt + 8'd1;
                        m_rep = 0;
                    end
                end
            end else begin
`ifdef FLAP_AUTO_REPEAT_EN
                if (m_lvl && m_run == 0) begin
                    m_rep++;
                    if (m_rep == R) begin
                        m_rep = 0;
                        p = 1'b1;
                        m_cnt = m_cnt + 8'd1;
                    end
                end
`endif
                m_run = 0;
            end
        end
        e.lvl = m_lvl;
        e.pulse = p;
        e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) step(v, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                vectors++;
                if (bus.btn_level !== e.lvl ||
                    bus.flap_pulse !== e.pulse ||
                    bus.press_count !== e.cnt) begin
                    miscompares++;
                    $display("FAIL out t=%0t lvl/pulse/cnt got %b/%b/%0d want %b/%b/%0d",
                             $time, bus.btn_level, bus.flap_pulse,
                             bus.press_count, e.lvl, e.pulse, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        int len;
        bit v;
        reset = 1'b1;
        bus.btn_raw = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        hold(1'b0, 20);
        hold(1'b1, 30);
        hold(1'b0, 10);
        for (int w = 1; w <= 3; w++) begin
            hold(1'b1, w);
            hold(1'b0, 2);
        end
        hold(1'b0, 8);
        hold(1'b1, 12);
        hold(1'b0, 2);
        hold(1'b1, 12);
        hold(1'b0, 10);
        for (int k = 0; k < 256; k++) begin
            hold(1'b1, 6);
            hold(1'b0, 6);
        end
        hold(1'b0, 4);
        hold(1'b1, 4);
        step(1'b1, 1'b1);
        hold(1'b1, 12);
        hold(1'b0, 8);
        hold(1'b1, 5);
        step(1'b1, 1'b1);
        hold(1'b1, 10);
        hold(1'b0, 8);
        hold(1'b1, 40);
        hold(1'b0, 8);
        for (int k = 0; k < 300; k++) begin
            v = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            if ($urandom_range(0, 49) == 0) step(v, 1'b1);
            hold(v, len);
        end
        hold(1'b0, 8);
        @(posedge clk);
        #5;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain left %0d want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flap_debouncer.md
FLAP_DEBOUNCER -- requirements
Module: flap_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the clk cycles the synchronized input must hold a level to be accepted (10 ms at 100 MHz).
REQ-002 Parameter REPEAT_CYCLES, default 15000000, SHALL set the auto-repeat flap interval in clk cycles (used only under REQ-024).
REQ-003 clk  input  1  system clock (100 MHz board clock); all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset (centre button).
REQ-005 btn_raw  input  1  raw, asynchronous, bouncing push-button (up button, flap).
REQ-006 btn_level  output  1  debounced button level, registered.
REQ-007 flap_pulse  output  1  one-clk-wide flap strobe to the game/VGA logic, registered.
REQ-008 press_count  output  8  count of flap_pulse strobes issued, for seven-segment debug.

Function
REQ-009 btn_raw SHALL pass through a 2-flop synchronizer (sync) before any other use; no other logic samples btn_raw.
REQ-010 FSM states SHALL be IDLE, PRESS_CHK, HELD, RELEASE_CHK; debounce counter width ceil(log2(DEBOUNCE_CYCLES))+1.
REQ-011 IDLE: sync=1 -> PRESS_CHK, counter cleared; else stay.
REQ-012 PRESS_CHK: sync=0 -> IDLE (glitch rejected, no pulse); counter reaching DEBOUNCE_CYCLES-1 with sync=1 -> HELD; else counter+1.
REQ-013 HELD: sync=0 -> RELEASE_CHK, counter cleared; else stay.
REQ-014 RELEASE_CHK: sync=1 -> HELD (no new pulse); counter reaching DEBOUNCE_CYCLES-1 with sync=0 -> IDLE; else counter+1.
REQ-015 btn_level SHALL be 1 exactly while state is HELD or RELEASE_CHK.
REQ-016 flap_pulse SHALL be high for exactly one clk, in the first cycle of HELD entered from PRESS_CHK; never on RELEASE_CHK->HELD.
REQ-017 Latency: btn_raw rising (setup met) and held stable -> flap_pulse high DEBOUNCE_CYCLES+2 cycles later.
REQ-018 press_count SHALL increment by 1 in the same edge flap_pulse is set; 255 wraps to 0.
REQ-019 Any sync=1 run shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no btn_level change.
REQ-020 Counters SHALL never exceed their terminal value; a held level in HELD/IDLE keeps the counter frozen.

Reset
REQ-021 reset SHALL asynchronously force state=IDLE, synchronizer flops=0, counters=0, btn_level=0, flap_pulse=0, press_count=0.
REQ-022 Reset asserted mid-debounce or while HELD SHALL discard progress; after release a still-pressed button requires a full new DEBOUNCE_CYCLES window and then yields one pulse.
REQ-023 reset SHALL dominate all simultaneous events, including a pulse due in the same cycle.

Configuration
REQ-024 With FLAP_AUTO_REPEAT_EN defined: a repeat counter SHALL run while in HELD (cleared on HELD entry, frozen in RELEASE_CHK) and SHALL issue an extra one-cycle flap_pulse (and press_count+1) every REPEAT_CYCLES cycles of continuous HELD.
REQ-025 Without FLAP_AUTO_REPEAT_EN: repeat counter and REPEAT_CYCLES logic SHALL be absent; exactly one flap_pulse per accepted press.

Verification (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
REQ-026 Reset asserted then released, btn_raw=0 -> all outputs 0, state IDLE for 20 cycles.
REQ-027 btn_raw 0->1, held 30 cycles -> one flap_pulse at cycle 6, btn_level=1 from cycle 6, press_count=1 (no macro).
REQ-028 btn_raw high-pulses of 1,2,3 cycles separated by 2 low cycles -> no flap_pulse, btn_level stays 0, press_count=0.
REQ-029 Press accepted, then 2-cycle low glitch during HELD -> btn_level stays 1, no second pulse; 256 clean presses -> press_count wraps to 0.
REQ-030 Reset asserted at cycle 4 of held press, released, button still high -> pulse 6 cycles after release, press_count=1.
REQ-031 FLAP_AUTO_REPEAT_EN defined, btn_raw held 40 cycles -> pulses at cycles 6, 16, 26, 36; press_count=4.
